pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline stall/flush controller for the five-stage MIPS core. It arbitrates stall requests from ID (load-use hazard) and EX (multi-cycle operations) against flush requests from MEM (exceptions/eret). It drives the 6-bit stall vector that every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb) obeys, and it sequences a one-cycle recovery window after each flush. It also keeps saturating performance counters and a sticky stall-timeout flag for debug.

## Interface
Parameters:
- MAX_STALL, 64: consecutive stalled cycles after which stall_timeout sets (≥2).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- stallreq_id  in  1  ID requests a stall (load-use).
- stallreq_ex  in  1  EX requests a stall (multi-cycle op busy).
- flush_req  in  1  MEM commits an exception or eret; flush the pipeline.
- flush_pc  in  32  redirect target accompanying flush_req.
- stall  out  6  stall vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- flush  out  1  flush all pipeline registers this cycle.
- new_pc  out  32  redirect target, valid when flush=1, else 0.
- stall_cycles  out  CNT_W  total cycles with stall≠0, saturating.
- flush_count  out  CNT_W  total flush cycles, saturating.
- stall_timeout  out  1  sticky: a continuous stall reached MAX_STALL cycles.

## Operation
- States: RUN, STALL_ID, STALL_EX, RECOVER (2-bit register).
- Priority each cycle: flush_req > stallreq_ex > stallreq_id.
- flush_req=1, any state: flush=1, new_pc=flush_pc, stall=6'b000000. Next state is RECOVER.
- Else, if the state is not RECOVER and stallreq_ex=1: stall=6'b001111, flush=0. Next state is STALL_EX.
- Else, if the state is not RECOVER and stallreq_id=1: stall=6'b000111. Next state is STALL_ID.
- Else: stall=0 and flush=0. Next state is RUN.
- In RECOVER, stallreq_id and stallreq_ex are ignored because they belong to squashed instructions. flush_req is still honoured.
- RECOVER lasts exactly one cycle unless a new flush arrives.
- Stall vectors keep the core invariant: for each stage, when it stalls, every earlier stage also stalls. When stall[2]=1 and stall[3]=0, id_ex injects a NOP bubble.
- Run counter (internal):
  - Increments in every cycle with stall≠0.
  - Clears in any cycle with stall=0, including flush cycles.
  - Saturates at MAX_STALL.
  - On the edge where it reaches MAX_STALL, stall_timeout sets. Only reset clears stall_timeout.
- stall_cycles increments on each edge where stall≠0. flush_count increments on each edge where flush=1. Both hold at all-ones and never wrap.
- While rst=0: stall, flush and new_pc are forced to 0 combinationally. At the clock edge, the state returns to RUN, and all counters and stall_timeout return to 0.

## Timing
- stall, flush and new_pc are combinational from the inputs and the current state, with zero latency. The requesting stage sees the response in the same cycle.
- The state, counters and stall_timeout are registered. They reflect a cycle's decision after the following rising edge.
- Flush followed by RECOVER: on edge N the state becomes RECOVER. During cycle N+1, stall is 0 regardless of the requests. On edge N+1 the state becomes RUN.
- Simultaneous flush_req and stallreq_*: the flush wins. The stall is dropped, and the run counter clears.
- Reset asserted mid-stall or mid-RECOVER takes effect at the next edge. Outputs are 0 for the whole reset cycle.
- Outputs have no combinational path from state to state. The requests must be stable before the edge.

## Structure
- Add to defines.v:
  - StallBus 5:0.
  - StallNone 6'b000000, StallId 6'b000111, StallEx 6'b001111.
  - Flush / NoFlush.
- State encodings are local parameters in pipe_ctrl.
- One sub-module, sat_counter (parameterised width, inc, clr, saturating), instantiated three times: stall_cycles, flush_count, and the run counter at width clog2(MAX_STALL+1).

## Test plan
- Reset: hold rst=0 for 2 cycles with all requests high. Required: stall=0, flush=0, new_pc=0, counters=0. After release with no requests: state RUN, stall=0.
- Load-use: stallreq_id=1 for 1 cycle. Required: stall=6'b000111 that cycle, stall_cycles=1 afterwards, next cycle stall=0.
- EX over ID: stallreq_ex=1 and stallreq_id=1 for 3 cycles. Required: stall=6'b001111 each cycle, stall_cycles=3.
- Flush priority and recovery:
  - Stimulus: flush_req=1 with flush_pc=32'h0000_0020 while stallreq_ex=1; the next cycle, stallreq_id=1.
  - Required: flush=1, new_pc=32'h20, stall=0 in the flush cycle; stall=0 (masked) in the next cycle; flush_count=1.
- Timeout with MAX_STALL=4:
  - Stimulus: stallreq_ex=1 for 3 cycles. Required: stall_timeout=0.
  - Stimulus: a 4th cycle. Required: stall_timeout=1 after that edge, staying set after the requests drop, until rst=0.
- Saturation with CNT_W=4: 20 stalled cycles. Required: stall_cycles=4'hF, no wrap.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared stall/flush encodings for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;

    localparam logic FLUSH    = 1'b1;
    localparam logic NO_FLUSH = 1'b0;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and active-low reset.
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && q != MAX) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush arbitration for the five-stage core, with a one-cycle
// recovery window after each flush and debug counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_STALL = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             stall_timeout
);

    localparam int RUN_W = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_STALL_ID = 2'd1,
        S_STALL_EX = 2'd2,
        S_RECOVER  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic             stall_any;
    logic [RUN_W-1:0] run_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_n;
        end
    end

    // Requests seen in RECOVER come from squashed instructions.
    always_comb begin
        stall   = STALL_NONE;
        flush   = NO_FLUSH;
        new_pc  = 32'h0;
        state_n = S_RUN;
        if (!rst) begin
            state_n = S_RUN;
        end else if (flush_req) begin
            flush   = FLUSH;
            new_pc  = flush_pc;
            state_n = S_RECOVER;
        end else if (state_q != S_RECOVER && stallreq_ex) begin
            stall   = STALL_EX;
            state_n = S_STALL_EX;
        end else if (state_q != S_RECOVER && stallreq_id) begin
            stall   = STALL_ID;
            state_n = S_STALL_ID;
        end
    end

    assign stall_any = (stall != STALL_NONE);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_any),
        .clr (1'b0),
        .q   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush),
        .clr (1'b0),
        .q   (flush_count)
    );

    sat_counter #(
        .W   (RUN_W),
        .MAX (RUN_W'(MAX_STALL))
    ) u_run_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_any),
        .clr (!stall_any),
        .q   (run_q)
    );

    // Sets on the same edge the run counter reaches MAX_STALL.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_timeout <= 1'b0;
        end else if (stall_any && run_q == RUN_W'(MAX_STALL - 1)) begin
            stall_timeout <= 1'b1;
        end
    end

endmodule
